// File: rtl/async_reset_seq_array_if.sv
// Reset-array bus: soft requests in, per-channel resets and status out.
// master drives rst_req; slave (the sequencer) drives the rest.
interface async_reset_seq_array_if #(
  parameter int N = 4
);
  logic [N-1:0] rst_req;
  logic [N-1:0] rst_n_out;
  logic         all_released;
  logic         busy;

  modport master (
    output rst_req,
    input  rst_n_out,
    input  all_released,
    input  busy
  );

  modport slave (
    input  rst_req,
    output rst_n_out,
    output all_released,
    output busy
  );
endinterface

// File: rtl/async_reset_seq_array.sv
// Reset distributor: sync'd release, staggered channels, soft pulses.
// CLK/ASYNCRESETN plain; bus carries rst_req, rst_n_out, status.
module async_reset_seq_array #(
  parameter int N         = 4,
  parameter int STAGES    = 2,
  parameter int GAP       = 3,
  parameter int MIN_PULSE = 4
) (
  input  logic CLK,
  input  logic ASYNCRESETN,
  async_reset_seq_array_if.slave bus
);

  localparam int M1 =
    (GAP > MIN_PULSE) ? GAP : MIN_PULSE;
  localparam int MX = (M1 > N) ? M1 : N;
  localparam int CW = $clog2(MX) + 1;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    SEQ  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_nxt;
  logic [STAGES-1:0] sync_q;
  logic            sync_done;
  logic [CW-1:0]   idx_q;
  logic [CW-1:0]   idx_nxt;
  logic [CW-1:0]   gap_q;
  logic [CW-1:0]   gap_nxt;
  logic [N-1:0]    out_q;
  logic [N-1:0]    out_nxt;
  logic [N-1:0]    soft_q;
  logic [N-1:0]    soft_nxt;
  logic [CW-1:0]   cnt_q   [N];
  logic [CW-1:0]   cnt_nxt [N];
  logic            all_q;
  logic            busy_q;

  assign sync_done = sync_q[STAGES-1];

  // Outputs are computed as next-state so that the
  // status flops update on the same edge as rst_n_out.
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    gap_nxt   = gap_q;
    out_nxt   = out_q;
    soft_nxt  = soft_q;
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i] = cnt_q[i];
    end
    case (state_q)
      HOLD: begin
        if (sync_done) begin
          out_nxt[0] = 1'b1;
          idx_nxt    = CW'(1);
          gap_nxt    = CW'(GAP - 1);
          state_nxt  = (N == 1) ? RUN : SEQ;
        end
      end
      SEQ: begin
        if (gap_q == '0) begin
          out_nxt = out_q | (N'(1) << idx_q);
          idx_nxt = idx_q + CW'(1);
          gap_nxt = CW'(GAP - 1);
          if (idx_q == CW'(N - 1)) begin
            state_nxt = RUN;
          end
        end else begin
          gap_nxt = gap_q - CW'(1);
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (bus.rst_req[i]) begin
            soft_nxt[i] = 1'b1;
            cnt_nxt[i]  = CW'(MIN_PULSE - 1);
            out_nxt[i]  = 1'b0;
          end else if (soft_q[i]) begin
            if (cnt_q[i] == '0) begin
              soft_nxt[i] = 1'b0;
              out_nxt[i]  = 1'b1;
            end else begin
              cnt_nxt[i] = cnt_q[i] - CW'(1);
            end
          end
        end
      end
      default: state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      sync_q  <= '0;
      state_q <= HOLD;
      idx_q   <= '0;
      gap_q   <= '0;
      out_q   <= '0;
      soft_q  <= '0;
      all_q   <= 1'b0;
      busy_q  <= 1'b1;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], 1'b1};
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      gap_q   <= gap_nxt;
      out_q   <= out_nxt;
      soft_q  <= soft_nxt;
      all_q   <= &out_nxt;
      busy_q  <= (state_nxt != RUN)
               || (|soft_nxt);
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_nxt[i];
      end
    end
  end

  assign bus.rst_n_out    = out_q;
  assign bus.all_released = all_q;
  assign bus.busy         = busy_q;

endmodule
